ram_arbiter: RTL and testbench

Two-port arbiter sharing the single 1024×10 paired-word RAM between two requesters, e.g. instruction fetch and data load/store. It serialises accesses onto the RAM's `mem_req`/`mem_ready` handshake and owns the tristate control of the shared 20-bit bidirectional data bus. It returns read data and a one-cycle acknowledge to the granted requester. It sits between the cache/CPU front ends and the RAM.

---
 rtl/ram_arbiter_if.sv | 43 ++++
 rtl/ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
//
// Requester-side bundle of the two-port RAM arbiter. The master modport is the
// view of the two front ends (instruction fetch / data load-store); the slave
// modport is the arbiter's view.
//
// Signals:
//   req0/req1     request per port, held until the matching ack
//   we0/we1       1 = write, 0 = read
//   addr0/addr1   AW-bit word address per port
//   wdata0/wdata1 DW-bit write data per port
//   ack0/ack1     one-cycle completion pulse for the granted port
//   rdata         read data, valid while the matching ack is high
//   busy          arbiter is not IDLE
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 20
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one 1024x10 paired-word RAM between two requesters. One access at a
// time is serialised onto the RAM mem_req/mem_ready handshake, and the
// arbiter owns the tristate control of the shared 20-bit data bus.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   req_if     requester bundle (ram_arbiter_if.slave): req/we/addr/wdata per
//              port in, ack0/ack1, rdata, busy out
//   mem_req    one-cycle RAM request (ISSUE state only)
//   mem_we     RAM write enable (latched, held for the whole access)
//   mem_addr   RAM address (latched, held for the whole access)
//   mem_data   bidirectional RAM data bus; driven only in ISSUE on a write
//   mem_ready  RAM ready
//
// Configuration:
//   RAM_ARB_ROUND_ROBIN_EN  defined   -> round-robin, the port not granted
//                                        last wins a tie (port 0 first)
//                           undefined -> fixed priority, port 0 wins a tie
//
// Access sequence: IDLE -> ISSUE -> WAITLO -> WAITHI -> DONE -> IDLE,
// giving a 5-cycle request-to-ack latency and one access per 6 cycles.
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  req_if,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data,
  input  logic          mem_ready
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAITLO,
    WAITHI,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;   // 0 = port 0, 1 = port 1
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic any_req;
  logic win1;                        // port 1 wins the current arbitration

  assign any_req = req_if.req0 | req_if.req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Last granted port; resets to port 1 so port 0 wins the first tie.
  logic last_q, last_d;

  assign win1 = req_if.req1 & (~req_if.req0 | ~last_q);
`else
  // Fixed priority: port 1 only wins when port 0 is not asking.
  assign win1 = ~req_if.req0;
`endif

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        // The RAM has no reset, so a grant also waits for it to be ready.
        if (mem_ready && any_req) begin
          grant_d = win1;
          we_d    = win1 ? req_if.we1    : req_if.we0;
          addr_d  = win1 ? req_if.addr1  : req_if.addr0;
          wdata_d = win1 ? req_if.wdata1 : req_if.wdata0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d  = win1;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAITLO;
      end
      WAITLO: begin
        // The RAM acknowledges the request by dropping ready.
        if (!mem_ready) begin
          state_d = WAITHI;
        end
      end
      WAITHI: begin
        if (mem_ready) begin
          if (!we_q) begin
            rdata_d = mem_data;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign mem_req  = (state_q == ISSUE);
  assign mem_we   = we_q;
  assign mem_addr = addr_q;

  // The RAM drives the bus except while it is idle with a write pending, so
  // the arbiter may only drive it in ISSUE for a write.
  assign mem_data = (state_q == ISSUE && we_q) ? wdata_q : {DW{1'bz}};

  assign req_if.ack0  = (state_q == DONE) && !grant_q;
  assign req_if.ack1  = (state_q == DONE) &&  grant_q;
  assign req_if.rdata = rdata_q;
  assign req_if.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter with a behavioural paired-word RAM. Expected
// acknowledges (port and rdata) are queued when a request is driven and
// popped when the arbiter acknowledges. Handshake rules on mem_req and the
// data bus are watched on every falling edge.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 20;

  localparam logic [DW-1:0] JUNK   = 20'hABCDE;   // wdata on reads
  localparam logic [DW-1:0] RD_A10 = 20'h02805;   // {ram[11], ram[10]}
  localparam logic [DW-1:0] RD_A12 = 20'h55407;   // {ram[13], 7} after write
  localparam logic [DW-1:0] RD_A20 = 20'hF0CAA;   // {ram[21], ram[20]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW), .DW(DW)) rif ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_ready;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_if   (rif),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ready(mem_ready)
  );

  // ---------------- behavioural RAM (no reset) ----------------
  logic [9:0]    ram [1024];
  logic [1:0]    ram_cnt = 2'd0;
  logic          ram_load = 1'b1;
  logic [DW-1:0] ram_rd;

  assign mem_ready = (ram_cnt == 2'd0);
  assign ram_rd    = {ram[{mem_addr[AW-1:1], 1'b1}], ram[{mem_addr[AW-1:1], 1'b0}]};
  assign mem_data  = (mem_ready && mem_we) ? {DW{1'bz}} : ram_rd;

  always @(posedge clk) begin
    if (ram_load) begin
      ram[0]  <= 10'd0;
      ram[1]  <= 10'd0;
      ram[10] <= 10'd5;
      ram[11] <= 10'd10;
      ram[12] <= 10'd0;
      ram[13] <= 10'h155;
      ram[20] <= 10'h0AA;
      ram[21] <= 10'h3C3;
    end else if (mem_req) begin
      ram_cnt <= 2'd2;
      if (mem_we) begin
        if (mem_addr[0]) ram[mem_addr] <= mem_data[19:10];
        else             ram[mem_addr] <= mem_data[9:0];
      end
    end else if (ram_cnt != 2'd0) begin
      ram_cnt <= ram_cnt - 2'd1;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic          port;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (mem_req) begin
      check("mem_req_consecutive", {31'd0, prev_req}, 32'd0);
      check("mem_req_ready_low", {31'd0, mem_ready}, 32'd1);
    end
    if (!mem_ready) begin
      check("bus_driven_ready_low", {12'd0, mem_data}, {12'd0, ram_rd});
    end
    if (rif.ack0 || rif.ack1) begin
      ack_cnt <= ack_cnt + 1;
      check("ack_onehot", {31'd0, rif.ack0 & rif.ack1}, 32'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_ack_port", {31'd0, rif.ack1}, {31'd0, e.port});
        check("sb_rdata", {12'd0, rif.rdata}, {12'd0, e.rdata});
      end
    end
    prev_req <= mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port) begin
      rif.req1 = req; rif.we1 = we; rif.addr1 = addr; rif.wdata1 = wdata;
    end else begin
      rif.req0 = req; rif.we0 = we; rif.addr0 = addr; rif.wdata0 = wdata;
    end
  endtask

  // One access from an idle arbiter; entered just after a rising edge, so the
  // current cycle is M.
  task automatic access(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
    int lat;
    drive(port, 1'b1, we, addr, wdata);
    sb.push_back('{port, exp_rdata});
    @(posedge clk); #1;                                    // M+1
    check("issue_mem_req", {31'd0, mem_req}, 32'd1);
    check("issue_busy", {31'd0, rif.busy}, 32'd1);
    check("issue_mem_we", {31'd0, mem_we}, {31'd0, we});
    check("issue_mem_addr", {22'd0, mem_addr}, {22'd0, addr});
    if (we) check("issue_bus_wdata", {12'd0, mem_data}, {12'd0, wdata});
    @(posedge clk); #1;                                    // M+2
    check("waitlo_mem_req", {31'd0, mem_req}, 32'd0);
    lat = 2;
    while (!(port ? rif.ack1 : rif.ack0) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ack_latency", lat, 32'd5);
    drive(port, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;                                    // M+6
    check("ack_one_cycle", {31'd0, rif.ack0 | rif.ack1}, 32'd0);
    check("idle_busy", {31'd0, rif.busy}, 32'd0);
  endtask

  task automatic apply_reset();
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int seen;
    int cyc;

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 ram_load = 1'b0;

    // Reset values
    check("rst_ack0", {31'd0, rif.ack0}, 32'd0);
    check("rst_ack1", {31'd0, rif.ack1}, 32'd0);
    check("rst_rdata", {12'd0, rif.rdata}, 32'd0);
    check("rst_busy", {31'd0, rif.busy}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_bus_released", {12'd0, mem_data}, {12'd0, ram_rd});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Read after reset, write (rdata unchanged), read-back of the written word
    access(1'b0, 1'b0, 10'd10, JUNK, RD_A10);
    access(1'b1, 1'b1, 10'd12, 20'h00007, RD_A10);
    access(1'b0, 1'b0, 10'd12, JUNK, RD_A12);

    // Reset in WAITLO, then a held req0 waits for the RAM to become ready
    base = ack_cnt;
    drive(1'b0, 1'b1, 1'b0, 10'd10, JUNK);
    @(posedge clk); #1;                                    // M+1 ISSUE
    @(posedge clk); #1;                                    // M+2 WAITLO
    rst = 1'b1;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_busy", {31'd0, rif.busy}, 32'd0);
    check("midrst_ack0", {31'd0, rif.ack0}, 32'd0);
    check("midrst_bus", {12'd0, mem_data}, {12'd0, ram_rd});
    check("midrst_rdata", {12'd0, rif.rdata}, 32'd0);
    @(posedge clk); #1;                                    // M+3, RAM not ready
    rst = 1'b0;
    sb.push_back('{1'b0, RD_A10});
    @(posedge clk); #1;                                    // M+4
    check("postrst_no_grant", {31'd0, mem_req}, 32'd0);
    check("postrst_idle", {31'd0, rif.busy}, 32'd0);
    @(posedge clk); #1;                                    // M+5
    check("postrst_grant", {31'd0, mem_req}, 32'd1);
    cyc = 0;
    while (!rif.ack0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("postrst_ack_latency", cyc, 32'd4);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check("midrst_ack_count", ack_cnt - base, 32'd1);

    // Simultaneous held requests
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 10'd10, JUNK);
    drive(1'b1, 1'b1, 1'b0, 10'd20, JUNK);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    sb.push_back('{1'b0, RD_A10});
    sb.push_back('{1'b1, RD_A20});
    sb.push_back('{1'b0, RD_A10});
    sb.push_back('{1'b1, RD_A20});
`else
    repeat (4) sb.push_back('{1'b0, RD_A10});
`endif
    seen = 0;
    cyc  = 0;
    while (seen < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (rif.ack0 || rif.ack1) begin
        seen++;
        if (seen == 4) begin
          drive(1'b0, 1'b0, 1'b0, '0, '0);
          drive(1'b1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    check("tie_acks_seen", seen, 32'd4);
    @(posedge clk); #1;
    base = ack_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("tie_no_extra_ack", ack_cnt - base, 32'd0);
    check("sb_drained", sb.size(), 32'd0);
    check("final_idle", {31'd0, rif.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
